keypad_scan_controller: RTL and testbench

- Scans the 4x4 button matrix on the GPIO header, debounces it and detects new presses.
- Queues at most one press and releases it as a one-cycle write strobe, with row/column coordinates, on the falling edge of vertical sync.
- Colour-storage writes therefore land only during vertical blanking, never mid-frame.
- Sits between the GPIO pins, the vertical sync generator and the colour storage block; replaces the free-running button scanner.

---
 rtl/keypad_scan_controller.sv | 177 +++++++++++++++++
 tb/tb_keypad_scan_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_controller.sv
// Keypad scan controller: scans a 4x4 active-high button matrix one column
// at a time. It debounces complete scans, picks the lowest-index new press,
// and holds it in a one-entry queue. On the next vsync falling edge the
// queued press is released as a single write strobe, so colour-storage
// writes only happen during vertical blanking.
module keypad_scan_controller #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [3:0] i_row_in,
   output logic [3:0] o_col_out,
   input  logic       i_vsync,
   input  logic       i_clr_ovf,
   output logic [1:0] o_key_h,
   output logic [1:0] o_key_v,
   output logic       o_wr_stb,
   output logic       o_pending,
   output logic       o_overflow
);

   localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
   localparam int SW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

   logic [3:0]    r_row_meta;
   logic [3:0]    r_row_sync;
   logic [DW-1:0] r_dwell;
   logic [1:0]    r_col;
   logic [3:0]    r_col_out;
   logic [15:0]   r_snap;
   logic [15:0]   r_prev;
   logic [15:0]   r_deb;
   logic [SW-1:0] r_stable;
   logic          r_eval;
   logic          r_pend_vld;
   logic [1:0]    r_pend_h;
   logic [1:0]    r_pend_v;
   logic [1:0]    r_key_h;
   logic [1:0]    r_key_v;
   logic          r_wr_stb;
   logic          r_overflow;
   logic          r_vsync_prev;

   logic          w_dwell_end;
   logic [15:0]   w_snap_nxt;
   logic [SW-1:0] w_stable_nxt;
   logic          w_debounce_hit;
   logic [15:0]   w_new_press;
   logic          w_press_vld;
   logic [3:0]    w_press_idx;
   logic          w_vs_fall;
   logic          w_drain;

   assign w_dwell_end = (r_dwell == DWELL_LAST);

   // Merge the synchronized rows of the driven column into the snapshot.
   // Bit index is row*4 + column.
   always_comb begin
      w_snap_nxt = r_snap;
      case (r_col)
         2'd0:    {w_snap_nxt[12], w_snap_nxt[8], w_snap_nxt[4], w_snap_nxt[0]} = r_row_sync;
         2'd1:    {w_snap_nxt[13], w_snap_nxt[9], w_snap_nxt[5], w_snap_nxt[1]} = r_row_sync;
         2'd2:    {w_snap_nxt[14], w_snap_nxt[10], w_snap_nxt[6], w_snap_nxt[2]} = r_row_sync;
         default: {w_snap_nxt[15], w_snap_nxt[11], w_snap_nxt[7], w_snap_nxt[3]} = r_row_sync;
      endcase
   end

   // Stable-scan count for this evaluation: saturate on a repeat, restart on a change.
   always_comb begin
      w_stable_nxt = SW'(1);
      if (r_snap == r_prev) begin
         w_stable_nxt = (r_stable == STABLE_MAX) ? r_stable : r_stable + SW'(1);
      end
   end

   assign w_debounce_hit = r_eval && (w_stable_nxt == STABLE_MAX);
   assign w_new_press    = w_debounce_hit ? (r_snap & ~r_deb) : 16'h0000;
   assign w_press_vld    = |w_new_press;

   // Lowest set bit wins; the other simultaneous presses are dropped silently.
   always_comb begin
      w_press_idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (w_new_press[i]) begin
            w_press_idx = 4'(i);
         end
      end
   end

   assign w_vs_fall = r_vsync_prev & ~i_vsync;
   assign w_drain   = w_vs_fall & r_pend_vld;

   // Row synchronizer, column dwell timer, column drive and snapshot capture.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_row_meta <= 4'h0;
         r_row_sync <= 4'h0;
         r_dwell    <= '0;
         r_col      <= 2'd0;
         r_col_out  <= 4'b0001;
         r_snap     <= 16'h0000;
         r_eval     <= 1'b0;
      end else begin
         r_row_meta <= i_row_in;
         r_row_sync <= r_row_meta;
         r_eval     <= w_dwell_end && (r_col == 2'd3);
         if (w_dwell_end) begin
            r_dwell   <= '0;
            r_col     <= r_col + 2'd1;
            r_col_out <= {r_col_out[2:0], r_col_out[3]};
            r_snap    <= w_snap_nxt;
         end else begin
            r_dwell   <= r_dwell + DW'(1);
         end
      end
   end

   // Debounce: update the stable count once per complete scan; commit D when it saturates.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prev   <= 16'h0000;
         r_deb    <= 16'h0000;
         r_stable <= '0;
      end else if (r_eval) begin
         r_stable <= w_stable_nxt;
         r_prev   <= r_snap;
         if (w_stable_nxt == STABLE_MAX) begin
            r_deb <= r_snap;
         end
      end
   end

   // One-entry press queue, drained by a vsync falling edge into a strobe.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vsync_prev <= 1'b1;
         r_wr_stb     <= 1'b0;
         r_key_h      <= 2'd0;
         r_key_v      <= 2'd0;
         r_pend_vld   <= 1'b0;
         r_pend_h     <= 2'd0;
         r_pend_v     <= 2'd0;
         r_overflow   <= 1'b0;
      end else begin
         r_vsync_prev <= i_vsync;
         r_wr_stb     <= w_drain;
         if (w_drain) begin
            r_key_h <= r_pend_h;
            r_key_v <= r_pend_v;
         end
         if (w_press_vld && (!r_pend_vld || w_drain)) begin
            r_pend_vld <= 1'b1;
            r_pend_h   <= w_press_idx[1:0];
            r_pend_v   <= w_press_idx[3:2];
         end else if (w_drain) begin
            r_pend_vld <= 1'b0;
         end
         // A drop in the same cycle as a clear request leaves the flag set.
         if (w_press_vld && r_pend_vld && !w_drain) begin
            r_overflow <= 1'b1;
         end else if (i_clr_ovf) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign o_col_out  = r_col_out;
   assign o_key_h    = r_key_h;
   assign o_key_v    = r_key_v;
   assign o_wr_stb   = r_wr_stb;
   assign o_pending  = r_pend_vld;
   assign o_overflow = r_overflow;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Bench for keypad_scan_controller with SCAN_DIV=4 and DEBOUNCE_SCANS=2.
// A behavioural 4x4 matrix drives the rows from the column drive and the
// set of held keys.
module tb_keypad_scan_controller;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 2;
   localparam int SCAN     = 4 * SCAN_DIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] keys = 16'h0000;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic        vsync = 1'b1;
   logic        clr_ovf = 1'b0;
   logic [1:0]  key_h;
   logic [1:0]  key_v;
   logic        wr_stb;
   logic        pending;
   logic        overflow;

   int errors = 0;
   int checks = 0;

   keypad_scan_controller #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEB)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_row_in   (row_in),
      .o_col_out  (col_out),
      .i_vsync    (vsync),
      .i_clr_ovf  (clr_ovf),
      .o_key_h    (key_h),
      .o_key_v    (key_v),
      .o_wr_stb   (wr_stb),
      .o_pending  (pending),
      .o_overflow (overflow)
   );

   always #5 clk = ~clk;

   // Key at (row r, column c) connects column c to row r while held.
   always_comb begin
      row_in = 4'h0;
      for (int r = 0; r < 4; r++) begin
         row_in[r] = |(keys[r*4 +: 4] & col_out);
      end
   end

   typedef struct {
      logic       vsync;
      logic       clr;
      logic [3:0] exp_col;
      logic       exp_stb;
      logic       exp_pend;
      logic       exp_ovf;
      logic [1:0] exp_kh;
      logic [1:0] exp_kv;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Pulse vsync low for one cycle and count the strobes that follow.
   task automatic pulse_vsync(output int n_stb, output logic [1:0] kh, output logic [1:0] kv);
      n_stb = 0;
      kh = 2'd0;
      kv = 2'd0;
      vsync = 1'b0;
      @(negedge clk);
      vsync = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (wr_stb === 1'b1) begin
            n_stb++;
            kh = key_h;
            kv = key_v;
         end
         @(negedge clk);
      end
   endtask

   // which: 0 = pending, 1 = overflow
   task automatic wait_flag(input int which, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if ((which == 0 && pending === 1'b1) || (which == 1 && overflow === 1'b1)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Returns at the first negedge of column 0, just before the debounce evaluation edge.
   task automatic wait_scan_start(output bit ok);
      logic [3:0] prev;
      ok = 1'b0;
      prev = col_out;
      for (int k = 0; k < 3 * SCAN; k++) begin
         @(negedge clk);
         if (prev == 4'b1000 && col_out == 4'b0001) begin
            ok = 1'b1;
            break;
         end
         prev = col_out;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] col_seq[5];
      bit         ok;
      bit         found;
      int         n;
      int         total;
      logic [1:0] kh;
      logic [1:0] kv;

      col_seq[0] = 4'b0001;
      col_seq[1] = 4'b0010;
      col_seq[2] = 4'b0100;
      col_seq[3] = 4'b1000;
      col_seq[4] = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         vecs[i] = '{vsync: 1'b1, clr: 1'b0, exp_col: col_seq[i/4],
                     exp_stb: 1'b0, exp_pend: 1'b0, exp_ovf: 1'b0,
                     exp_kh: 2'd0, exp_kv: 2'd0};
      end
      vecs[5].vsync  = 1'b0;
      vecs[6].vsync  = 1'b0;
      vecs[13].vsync = 1'b0;
      vecs[9].clr    = 1'b1;

      // Reset and column walk; vsync edges with an empty queue do nothing.
      tick(2);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         vsync   = vecs[i].vsync;
         clr_ovf = vecs[i].clr;
         check($sformatf("vec%0d", i),
               {21'd0, col_out, wr_stb, pending, overflow, key_h, key_v},
               {21'd0, vecs[i].exp_col, vecs[i].exp_stb, vecs[i].exp_pend,
                vecs[i].exp_ovf, vecs[i].exp_kh, vecs[i].exp_kv});
         tick(1);
      end
      vsync = 1'b1;
      clr_ovf = 1'b0;

      // Single key (row 2, column 2) held, then one vsync.
      keys[10] = 1'b1;
      wait_flag(0, 5 * SCAN, ok);
      check("t2_pending_set", ok, 1);
      check("t2_no_early_stb", {wr_stb, key_h, key_v}, 5'b0);
      pulse_vsync(n, kh, kv);
      check("t2_one_strobe", n, 1);
      check("t2_key_v", kv, 2);
      check("t2_key_h", kh, 2);
      check("t2_pending_clr", pending, 0);
      tick(7);
      check("t2_key_hold", {key_v, key_h}, 4'b1010);
      keys = 16'h0000;
      tick(4 * SCAN);

      // Bouncing key: row 1 column 0 toggles every scan.
      wait_scan_start(ok);
      check("t3_scan_align", ok, 1);
      total = 0;
      for (int s = 0; s < 6; s++) begin
         keys[4] = (s % 2 == 0);
         if (s < 3) begin
            pulse_vsync(n, kh, kv);
            total += n;
            tick(SCAN - 5);
         end else begin
            tick(SCAN);
         end
         check($sformatf("t3_no_pending_%0d", s), pending, 0);
      end
      check("t3_no_strobes", total, 0);
      keys = 16'h0000;
      tick(3 * SCAN);
      check("t3_quiet", {pending, overflow}, 2'b00);

      // Two keys at once: (0,3) beats (3,0); no repeat while held.
      keys[3]  = 1'b1;
      keys[12] = 1'b1;
      wait_flag(0, 5 * SCAN, ok);
      check("t4_pending_set", ok, 1);
      pulse_vsync(n, kh, kv);
      check("t4_one_strobe", n, 1);
      check("t4_key_v", kv, 0);
      check("t4_key_h", kh, 3);
      total = 0;
      for (int p = 0; p < 5; p++) begin
         tick(20);
         pulse_vsync(n, kh, kv);
         total += n;
      end
      check("t4_no_repeat", total, 0);
      check("t4_no_pending", pending, 0);
      keys = 16'h0000;
      tick(4 * SCAN);

      // Press A (1,1), release, press B (3,2) with no vsync: B is dropped.
      keys[5] = 1'b1;
      wait_flag(0, 5 * SCAN, ok);
      check("t5_a_pending", ok, 1);
      keys[5] = 1'b0;
      tick(4 * SCAN);
      check("t5_a_still_queued", {pending, overflow}, 2'b10);
      keys[14] = 1'b1;
      wait_flag(1, 5 * SCAN, ok);
      check("t5_overflow_set", ok, 1);
      check("t5_pending_kept", pending, 1);
      pulse_vsync(n, kh, kv);
      check("t5_one_strobe", n, 1);
      check("t5_strobes_a", {kv, kh}, 4'b0101);
      check("t5_pending_clr", pending, 0);
      check("t5_ovf_sticky", overflow, 1);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      check("t5_ovf_cleared", overflow, 0);
      keys[14] = 1'b0;
      tick(4 * SCAN);

      // Queue C (0,0), then an overflow that coincides with a clear request.
      keys[0] = 1'b1;
      wait_flag(0, 5 * SCAN, ok);
      check("t5_c_pending", ok, 1);
      keys[0] = 1'b0;
      tick(4 * SCAN);
      check("t5_ovf_before", overflow, 0);
      keys[15] = 1'b1;
      found = 1'b0;
      for (int s = 0; s < 8 && !found; s++) begin
         wait_scan_start(ok);
         clr_ovf = 1'b1;
         tick(1);
         clr_ovf = 1'b0;
         if (overflow === 1'b1) found = 1'b1;
      end
      check("t5_set_beats_clear", found, 1);
      check("t5_c_still_pending", pending, 1);
      keys = 16'h0000;
      tick(2);

      // Reset while a press is queued discards it.
      check("t6_pending_before", pending, 1);
      rst_n = 1'b0;
      #1;
      check("t6_reset_outputs",
            {21'd0, col_out, wr_stb, pending, overflow, key_h, key_v},
            {21'd0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0});
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);
      pulse_vsync(n, kh, kv);
      check("t6_no_strobe", n, 0);
      check("t6_no_pending", pending, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
